serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. One full-adder bit is evaluated per clock, LSB
// first, so a WIDTH-bit operation takes WIDTH+2 cycles from the accepting
// edge to the next accepting edge:
//   - the accepting edge (IDLE -> SHIFT),
//   - WIDTH shift edges (the last one moves SHIFT -> DONE),
//   - one DONE cycle.
// The result, carry and overflow are registered and only change on the
// SHIFT -> DONE transition. Between operations they hold the last result.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input port `sub`, captured together with A/B. When sub=1 the block
//   computes A-B by inverting B bit by bit and starting with carry-in 1.
//   In that mode Cout=1 means "no borrow". Without the macro the block only
//   adds and the port does not exist.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      begin an operation (only sampled in IDLE)
//   sub    in   1      subtract request (only with SERIAL_ADDER_SUB_EN)
//   A      in   WIDTH  first operand, captured on the accepting edge
//   B      in   WIDTH  second operand, captured on the accepting edge
//   busy   out  1      high whenever the FSM is not in IDLE
//   done   out  1      one-cycle pulse, Sum/Cout/Ovf valid
//   Sum    out  WIDTH  registered result
//   Cout   out  1      registered carry out of the MSB
//   Ovf    out  1      registered two's-complement overflow
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; outputs hold the last result
//   S_SHIFT | one full-adder bit per edge, LSB first
//   S_DONE  | result registers just updated; done=1 for this cycle
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    // Counter must be able to represent 0..WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Subtract mode: captured request, and the carry-in applied on accept.
    logic             invert_b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q, sub_d;

    assign invert_b = sub_q;
    assign carry_in = sub;
`else
    assign invert_b = 1'b0;
    assign carry_in = 1'b0;
`endif

    // Full-adder slice working on the current LSBs of the operand registers.
    logic bit_a;
    logic bit_b;
    logic bit_s;
    logic bit_c;

    assign bit_a = a_q[0];
    assign bit_b = b_q[0] ^ invert_b;
    assign bit_s = bit_a ^ bit_b ^ carry_q;
    assign bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = carry_in;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = bit_c;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB, bit_c the carry out.
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
